// File: rtl/mem_sub1_pkg.sv
// Shared definitions for the first memory stage (M1S): bus widths, the
// packed layout of the EX->M1S / M1S->M2S bus, request FSM encodings and
// a helper that assembles the forwarding bus.
package mem_sub1_pkg;

  localparam int ES_TO_M1S_BUS1_WD = 76;
  localparam int M1S_TO_M2S_BUS_WD = 76;
  localparam int M1S_FWD_BUS_WD    = 40;

  // Request FSM: IDLE (no outstanding work), REQ (driving the SRAM request),
  // ISSUED (address accepted, waiting for the entry to leave).
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ISSUED = 2'd2
  } m1s_state_e;

  // Field layout shared by es_to_m1s_bus and m1s_to_m2s_bus (MSB first).
  typedef struct packed {
    logic        first;
    logic [3:0]  rf_wen;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
  } m1s_bus_t;

  // Forwarding bus seen by decode: {valid, gr_we, is_load, dest, result}.
  function automatic logic [M1S_FWD_BUS_WD-1:0] packFwd(
    input logic        valid,
    input logic        grWe,
    input logic        isLoad,
    input logic [4:0]  dest,
    input logic [31:0] result
  );
    return {valid, grWe, isLoad, dest, result};
  endfunction

endpackage

// File: rtl/mem_sub1_req_fsm.sv
// Load-request sequencer for M1S. Tracks whether the resident entry still has
// to present its address to the data SRAM, has already had it accepted, or
// needs nothing, and derives the stage's ready_go from that.
module m1s_req_fsm
  import mem_sub1_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_latch,
  input  logic i_latch_is_load,
  input  logic i_leave,
  input  logic i_valid,
  input  logic i_res_from_mem,
  input  logic i_addr_ok,
  output logic o_req,
  output logic o_ready_go
);

  m1s_state_e r_state;
  m1s_state_e w_next;

  // State register; reset abandons any outstanding address handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state: a newly latched entry decides first, then a departing entry
  // returns to IDLE, otherwise REQ advances only on address acceptance.
  always_comb begin
    w_next = r_state;
    if (i_latch) begin
      w_next = i_latch_is_load ? REQ : IDLE;
    end else if (i_leave) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        REQ:     if (i_addr_ok) w_next = ISSUED;
        default: w_next = r_state;
      endcase
    end
  end

  // The request is a pure decode of registered state so addr_ok never loops
  // back into it; ISSUED keeps it low even if M2S stalls for a long time.
  assign o_req = i_valid & (r_state == REQ);

  // A load may move on in the very cycle its address is accepted.
  assign o_ready_go = !i_res_from_mem | (r_state == ISSUED) |
                      ((r_state == REQ) & i_addr_ok);

endmodule

// File: rtl/mem_sub1.sv
// First memory stage (M1S). Registers the EX result, issues exactly one data
// SRAM read request per load, drives the forwarding bus for decode and hands
// the entry to M2S. Optional stall counter enabled by MEM_SUB1_STALL_CNT_EN.
module mem_sub1
  import mem_sub1_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         es_to_m1s_valid,
  input  logic [ES_TO_M1S_BUS1_WD-1:0] es_to_m1s_bus,
  output logic                         m1s_allowin,
  input  logic                         m2s_allowin,
  output logic                         m1s_to_m2s_valid,
  output logic [M1S_TO_M2S_BUS_WD-1:0] m1s_to_m2s_bus,
  output logic [M1S_FWD_BUS_WD-1:0]    m1s_fwd_bus,
  output logic                         data_sram_req,
  output logic                         data_sram_wr,
  output logic [1:0]                   data_sram_size,
  output logic [31:0]                  data_sram_addr,
  input  logic                         data_sram_addr_ok,
  output logic [CNT_W-1:0]             m1s_stall_cnt
);

  logic     r_m1s_valid;
  m1s_bus_t r_bus;
  m1s_bus_t w_in_bus;
  logic     w_ready_go;
  logic     w_latch;
  logic     w_leave;
  logic     w_req;

  assign w_in_bus = m1s_bus_t'(es_to_m1s_bus);

  assign m1s_allowin      = !r_m1s_valid | (w_ready_go & m2s_allowin);
  assign w_latch          = es_to_m1s_valid & m1s_allowin;
  assign m1s_to_m2s_valid = r_m1s_valid & w_ready_go;
  assign w_leave          = m1s_to_m2s_valid & m2s_allowin;

  // Stage valid flag follows the upstream valid whenever the stage can accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_m1s_valid <= 1'b0;
    end else if (m1s_allowin) begin
      r_m1s_valid <= es_to_m1s_valid;
    end
  end

  // Payload register only moves on a real latch, so it stays put under stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bus <= '0;
    end else if (w_latch) begin
      r_bus <= w_in_bus;
    end
  end

  m1s_req_fsm u_req_fsm (
    .clk             (clk),
    .reset           (reset),
    .i_latch         (w_latch),
    .i_latch_is_load (w_in_bus.res_from_mem),
    .i_leave         (w_leave),
    .i_valid         (r_m1s_valid),
    .i_res_from_mem  (r_bus.res_from_mem),
    .i_addr_ok       (data_sram_addr_ok),
    .o_req           (w_req),
    .o_ready_go      (w_ready_go)
  );

  assign data_sram_req  = w_req;
  assign data_sram_wr   = 1'b0;
  assign data_sram_size = 2'b10;
  assign data_sram_addr = r_bus.result;

  assign m1s_to_m2s_bus = r_bus;

  // Decode must stall on a dest match while is_load is set; data is not ready.
  assign m1s_fwd_bus = packFwd(r_m1s_valid, r_bus.gr_we, r_bus.res_from_mem,
                               r_bus.dest, r_bus.result);

`ifdef MEM_SUB1_STALL_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;

  // Count cycles spent requesting without acceptance; saturates, reset-only clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_req && !data_sram_addr_ok && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign m1s_stall_cnt = r_stall_cnt;
`else
  assign m1s_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_sub1.sv
// Directed testbench for mem_sub1. Stimulus pushes the expected M1S->M2S bus
// into a queue; a monitor pops and compares on every handoff to M2S.
module tb_mem_sub1;

  localparam int CNT_W = 32;
`ifdef MEM_SUB1_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             es_to_m1s_valid;
  logic [75:0]      es_to_m1s_bus;
  logic             m1s_allowin;
  logic             m2s_allowin;
  logic             m1s_to_m2s_valid;
  logic [75:0]      m1s_to_m2s_bus;
  logic [39:0]      m1s_fwd_bus;
  logic             data_sram_req;
  logic             data_sram_wr;
  logic [1:0]       data_sram_size;
  logic [31:0]      data_sram_addr;
  logic             data_sram_addr_ok;
  logic [CNT_W-1:0] m1s_stall_cnt;

  int nChecks = 0;
  int nFails = 0;
  int reqCycles = 0;
  int reqHandshakes = 0;
  int leaveCount = 0;
  logic [75:0] expQ[$];

  always #5 clk = ~clk;

  mem_sub1 #(.CNT_W(CNT_W)) dut (
    .clk               (clk),
    .reset             (reset),
    .es_to_m1s_valid   (es_to_m1s_valid),
    .es_to_m1s_bus     (es_to_m1s_bus),
    .m1s_allowin       (m1s_allowin),
    .m2s_allowin       (m2s_allowin),
    .m1s_to_m2s_valid  (m1s_to_m2s_valid),
    .m1s_to_m2s_bus    (m1s_to_m2s_bus),
    .m1s_fwd_bus       (m1s_fwd_bus),
    .data_sram_req     (data_sram_req),
    .data_sram_wr      (data_sram_wr),
    .data_sram_size    (data_sram_size),
    .data_sram_addr    (data_sram_addr),
    .data_sram_addr_ok (data_sram_addr_ok),
    .m1s_stall_cnt     (m1s_stall_cnt)
  );

  function automatic logic [75:0] makeBus(input logic isLoad, input logic grWe,
                                          input logic [4:0] dest,
                                          input logic [31:0] result,
                                          input logic [31:0] pc);
    return {1'b1, (grWe ? 4'hf : 4'h0), isLoad, grWe, dest, result, pc};
  endfunction

  task automatic checkOutput(input string name, input logic [75:0] actual,
                             input logic [75:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [75:0] bus);
    es_to_m1s_valid = 1'b1;
    es_to_m1s_bus   = bus;
    expQ.push_back(bus);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  // Monitor: tally requests/handshakes and score every handoff to M2S.
  always @(negedge clk) begin
    if (!reset) begin
      if (data_sram_req) begin
        reqCycles++;
        if (data_sram_addr_ok) reqHandshakes++;
      end
      if (m1s_to_m2s_valid && m2s_allowin) begin
        leaveCount++;
        if (expQ.size() == 0) begin
          nChecks++;
          nFails++;
          $display("[TB] FAIL unexpectedLeave: got bus %h, expected no handoff", m1s_to_m2s_bus);
        end else begin
          checkOutput("leaveBus", m1s_to_m2s_bus, expQ.pop_front());
        end
      end
    end
  end

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r0, h0, l0;
    logic [31:0] expStall;
    logic [75:0] heldBus;
    logic [31:0] addrK;

    reset = 1'b1;
    es_to_m1s_valid = 1'b0;
    es_to_m1s_bus = '0;
    m2s_allowin = 1'b1;
    data_sram_addr_ok = 1'b0;
    repeat (2) tick();
    reset = 1'b0;

    // Reset state
    sample();
    checkOutput("resetOutValid", m1s_to_m2s_valid, 1'b0);
    checkOutput("resetReq", data_sram_req, 1'b0);
    checkOutput("resetAllowin", m1s_allowin, 1'b1);
    checkOutput("resetBus", m1s_to_m2s_bus, 76'd0);
    checkOutput("resetFwd", m1s_fwd_bus, 40'd0);
    checkOutput("resetStallCnt", m1s_stall_cnt, 32'd0);
    checkOutput("sramWr", data_sram_wr, 1'b0);
    checkOutput("sramSize", data_sram_size, 2'b10);
    tick();

    // ALU op passes straight through, no request
    r0 = reqCycles;
    applyStimulus(makeBus(1'b0, 1'b1, 5'd3, 32'h0000_1234, 32'h1c00_0010));
    sample();
    checkOutput("aluAllowin", m1s_allowin, 1'b1);
    tick();
    es_to_m1s_valid = 1'b0;
    sample();
    checkOutput("aluOutValid", m1s_to_m2s_valid, 1'b1);
    checkOutput("aluResult", m1s_to_m2s_bus[63:32], 32'h0000_1234);
    tick();
    sample();
    checkOutput("aluNoReq", reqCycles - r0, 0);
    checkOutput("aluDrained", m1s_to_m2s_valid, 1'b0);
    tick();

    // Load with addr_ok delayed 3 cycles, leaves in the addr_ok cycle
    r0 = reqCycles; h0 = reqHandshakes; l0 = leaveCount;
    applyStimulus(makeBus(1'b1, 1'b1, 5'd7, 32'h8000_1000, 32'h1c00_0020));
    sample();
    tick();
    es_to_m1s_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      data_sram_addr_ok = (i == 3);
      sample();
      checkOutput("delayReq", data_sram_req, 1'b1);
      checkOutput("delayAddr", data_sram_addr, 32'h8000_1000);
      checkOutput("delayOutValid", m1s_to_m2s_valid, (i == 3));
      tick();
    end
    data_sram_addr_ok = 1'b0;
    sample();
    checkOutput("delayReqCycles", reqCycles - r0, 4);
    checkOutput("delayHandshakes", reqHandshakes - h0, 1);
    checkOutput("delayLeaves", leaveCount - l0, 1);
    checkOutput("delayReqDropped", data_sram_req, 1'b0);
    expStall = STALL_EN ? 32'd3 : 32'd0;
    checkOutput("delayStallCnt", m1s_stall_cnt, expStall);
    tick();

    // Load accepted at once while M2S stalls 5 cycles
    r0 = reqCycles; h0 = reqHandshakes; l0 = leaveCount;
    m2s_allowin = 1'b0;
    heldBus = makeBus(1'b1, 1'b0, 5'd9, 32'h8000_1234, 32'h1c00_0030);
    applyStimulus(heldBus);
    sample();
    tick();
    es_to_m1s_valid = 1'b0;
    data_sram_addr_ok = 1'b1;
    sample();
    checkOutput("m2sStallReq", data_sram_req, 1'b1);
    checkOutput("m2sStallAllowin0", m1s_allowin, 1'b0);
    tick();
    data_sram_addr_ok = 1'b0;
    es_to_m1s_valid = 1'b1;
    es_to_m1s_bus = makeBus(1'b0, 1'b1, 5'd1, 32'hdead_beef, 32'h1c00_00ff);
    for (int i = 0; i < 4; i++) begin
      sample();
      checkOutput("m2sStallNoReq", data_sram_req, 1'b0);
      checkOutput("m2sStallValidHeld", m1s_to_m2s_valid, 1'b1);
      checkOutput("m2sStallAllowin", m1s_allowin, 1'b0);
      checkOutput("m2sStallBusStable", m1s_to_m2s_bus, heldBus);
      tick();
    end
    es_to_m1s_valid = 1'b0;
    m2s_allowin = 1'b1;
    sample();
    checkOutput("m2sStallRelease", m1s_to_m2s_valid, 1'b1);
    tick();
    sample();
    checkOutput("m2sStallReqCycles", reqCycles - r0, 1);
    checkOutput("m2sStallHandshakes", reqHandshakes - h0, 1);
    checkOutput("m2sStallLeaves", leaveCount - l0, 1);
    checkOutput("m2sStallDrained", m1s_to_m2s_valid, 1'b0);
    tick();

    // Back-to-back loads, one per cycle, one request each
    r0 = reqCycles; h0 = reqHandshakes; l0 = leaveCount;
    data_sram_addr_ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      addrK = 32'h8000_3000 + 32'(k * 4);
      applyStimulus(makeBus(1'b1, 1'b1, 5'(k + 10), addrK, 32'h1c00_0100 + 32'(k * 4)));
      sample();
      checkOutput("b2bAllowin", m1s_allowin, 1'b1);
      if (k > 0) begin
        checkOutput("b2bReq", data_sram_req, 1'b1);
        checkOutput("b2bAddr", data_sram_addr, addrK - 32'd4);
      end
      tick();
    end
    es_to_m1s_valid = 1'b0;
    sample();
    checkOutput("b2bLastReq", data_sram_req, 1'b1);
    checkOutput("b2bLastAddr", data_sram_addr, 32'h8000_300c);
    tick();
    data_sram_addr_ok = 1'b0;
    sample();
    checkOutput("b2bReqCycles", reqCycles - r0, 4);
    checkOutput("b2bHandshakes", reqHandshakes - h0, 4);
    checkOutput("b2bLeaves", leaveCount - l0, 4);
    tick();

    // Forwarding of a resident load to dest 5
    m2s_allowin = 1'b0;
    applyStimulus(makeBus(1'b1, 1'b1, 5'd5, 32'h8000_2000, 32'h1c00_0200));
    sample();
    tick();
    es_to_m1s_valid = 1'b0;
    data_sram_addr_ok = 1'b1;
    sample();
    checkOutput("fwdLoad", m1s_fwd_bus, {1'b1, 1'b1, 1'b1, 5'd5, 32'h8000_2000});
    tick();
    data_sram_addr_ok = 1'b0;
    m2s_allowin = 1'b1;
    sample();
    checkOutput("fwdStillValid", m1s_fwd_bus[39], 1'b1);
    tick();
    sample();
    checkOutput("fwdCleared", m1s_fwd_bus[39], 1'b0);
    tick();

    // Reset while requesting
    applyStimulus(makeBus(1'b1, 1'b1, 5'd6, 32'h8000_4000, 32'h1c00_0300));
    sample();
    tick();
    es_to_m1s_valid = 1'b0;
    sample();
    checkOutput("rstPreReq", data_sram_req, 1'b1);
    tick();
    sample();
    checkOutput("rstPreReq2", data_sram_req, 1'b1);
    expStall = STALL_EN ? 32'd4 : 32'd0;
    checkOutput("rstPreStallCnt", m1s_stall_cnt, expStall);
    tick();
    reset = 1'b1;
    expQ.delete();
    tick();
    reset = 1'b0;
    sample();
    checkOutput("rstReq", data_sram_req, 1'b0);
    checkOutput("rstValid", m1s_to_m2s_valid, 1'b0);
    checkOutput("rstAllowin", m1s_allowin, 1'b1);
    checkOutput("rstStallCnt", m1s_stall_cnt, 32'd0);
    checkOutput("rstFwdValid", m1s_fwd_bus[39], 1'b0);
    tick();

    // After reset the FSM is idle: an ALU op passes with no request
    r0 = reqCycles; l0 = leaveCount;
    applyStimulus(makeBus(1'b0, 1'b0, 5'd2, 32'h0000_5678, 32'h1c00_0400));
    sample();
    tick();
    es_to_m1s_valid = 1'b0;
    sample();
    checkOutput("postRstOutValid", m1s_to_m2s_valid, 1'b1);
    tick();
    sample();
    checkOutput("postRstNoReq", reqCycles - r0, 0);
    checkOutput("postRstLeaves", leaveCount - l0, 1);
    checkOutput("queueEmpty", expQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
